bn_param_feeder: RTL and testbench

- Sequencer that drives the Batch_Norm operand interface (Data_A scale, Data_B bias, Data_In, Valid_In).
- Loads per-channel scale/bias pairs into internal storage from a load stream.
- Then streams channel-major pixel data and presents each pixel with its channel's coefficients.
- Sits between the coefficient/feature-map memory fetch logic and the Batch_Norm datapath.

---
 rtl/bn_param_feeder.sv | 150 +++++++++++++++
 tb/tb_bn_param_feeder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bn_param_feeder.sv
// rtl/bn_param_feeder.sv - per-channel scale/bias loader and pixel sequencer for Batch_Norm
module bn_param_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CH     = 64,
    parameter int CH_W       = 7,
    parameter int PIX_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  Reload,
    input  logic [CH_W-1:0]       Num_Ch,
    input  logic [PIX_W-1:0]      Pix_Per_Ch,
    input  logic                  Load_Valid,
    input  logic [DATA_WIDTH-1:0] Load_Data,
    output logic                  Load_Ready,
    input  logic                  Pix_Valid,
    input  logic [DATA_WIDTH-1:0] Pix_Data,
    output logic                  Pix_Ready,
    output logic [DATA_WIDTH-1:0] Data_A,
    output logic [DATA_WIDTH-1:0] Data_B,
    output logic [DATA_WIDTH-1:0] Data_In,
    output logic                  Valid_In,
    output logic [CH_W-1:0]       Ch_Idx,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err
);
    localparam int AW = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

    state_t state, state_nx;

    logic [CH_W-1:0]       num_ch_r;
    logic [CH_W-1:0]       stored_ch;
    logic [CH_W-1:0]       ch;
    logic [PIX_W-1:0]      ppc_r;
    logic [PIX_W-1:0]      pix;
    logic [CH_W:0]         word_cnt;
    logic                  coef_valid;
    logic [DATA_WIDTH-1:0] mem_a [MAX_CH];
    logic [DATA_WIDTH-1:0] mem_b [MAX_CH];

    logic start_seen, start_bad, start_go, start_err;
    logic load_xfer, load_last, pix_xfer, pix_wrap, pix_last;

    // Start validation and transfer qualifiers
    always_comb begin
        start_seen = Start && (state == S_IDLE);
        start_bad  = (Num_Ch == '0) || (Num_Ch > CH_W'(MAX_CH)) || (Pix_Per_Ch == '0) ||
                     (!Reload && (Num_Ch > stored_ch));
        start_go   = start_seen && !start_bad;
        start_err  = start_seen && start_bad;
        load_xfer  = (state == S_LOAD) && Load_Valid;
        load_last  = load_xfer && (word_cnt == ({num_ch_r, 1'b0} - (CH_W+1)'(1)));
        pix_xfer   = (state == S_STREAM) && Pix_Valid;
        pix_wrap   = (pix == ppc_r - PIX_W'(1));
        pix_last   = pix_xfer && pix_wrap && (ch == num_ch_r - CH_W'(1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start_go) state_nx = (Reload || !coef_valid) ? S_LOAD : S_STREAM;
            S_LOAD:   if (load_last) state_nx = S_STREAM;
            S_STREAM: if (pix_last) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Run parameters, counters, coefficient-set bookkeeping and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_ch_r   <= '0;
            ppc_r      <= '0;
            ch         <= '0;
            pix        <= '0;
            word_cnt   <= '0;
            coef_valid <= 1'b0;
            stored_ch  <= '0;
            Err        <= 1'b0;
        end else begin
            Err <= start_err;
            if (start_seen) begin
                num_ch_r <= Num_Ch;
                ppc_r    <= Pix_Per_Ch;
                ch       <= '0;
                pix      <= '0;
                word_cnt <= '0;
            end
            if (load_xfer) begin
                word_cnt <= word_cnt + (CH_W+1)'(1);
                if (load_last) begin
                    coef_valid <= 1'b1;
                    stored_ch  <= num_ch_r;
                end
            end
            if (pix_xfer) begin
                if (pix_wrap) begin
                    pix <= '0;
                    ch  <= ch + CH_W'(1);
                end else begin
                    pix <= pix + PIX_W'(1);
                end
            end
        end
    end

    // Coefficient storage: even words are scales, odd words are biases
    always_ff @(posedge clk) begin
        if (load_xfer) begin
            if (word_cnt[0]) mem_b[word_cnt[AW:1]] <= Load_Data;
            else             mem_a[word_cnt[AW:1]] <= Load_Data;
        end
    end

    // Operand presentation, one cycle after each accepted pixel; holds on gaps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Valid_In <= 1'b0;
            Data_In  <= '0;
            Data_A   <= '0;
            Data_B   <= '0;
            Ch_Idx   <= '0;
        end else begin
            Valid_In <= pix_xfer;
            if (pix_xfer) begin
                Data_In <= Pix_Data;
                Data_A  <= mem_a[ch[AW-1:0]];
                Data_B  <= mem_b[ch[AW-1:0]];
                Ch_Idx  <= ch;
            end
        end
    end

    assign Busy       = (state != S_IDLE);
    assign Done       = (state == S_DONE);
    assign Load_Ready = (state == S_LOAD);
    assign Pix_Ready  = (state == S_STREAM);

endmodule

// File: tb/tb_bn_param_feeder.sv
// tb/tb_bn_param_feeder.sv - self-checking bench for bn_param_feeder
module tb_bn_param_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic        Start, Reload, Load_Valid, Pix_Valid;
    logic [6:0]  Num_Ch;
    logic [15:0] Pix_Per_Ch;
    logic [31:0] Load_Data, Pix_Data;
    logic        Load_Ready, Pix_Ready, Valid_In, Busy, Done, Err;
    logic [31:0] Data_A, Data_B, Data_In;
    logic [6:0]  Ch_Idx;

    bn_param_feeder dut (
        .clk(clk), .rst(rst), .Start(Start), .Reload(Reload), .Num_Ch(Num_Ch),
        .Pix_Per_Ch(Pix_Per_Ch), .Load_Valid(Load_Valid), .Load_Data(Load_Data),
        .Load_Ready(Load_Ready), .Pix_Valid(Pix_Valid), .Pix_Data(Pix_Data),
        .Pix_Ready(Pix_Ready), .Data_A(Data_A), .Data_B(Data_B), .Data_In(Data_In),
        .Valid_In(Valid_In), .Ch_Idx(Ch_Idx), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: stored coefficient set
    logic [31:0] m_a [64];
    logic [31:0] m_b [64];
    bit          m_coef_valid = 0;
    int          m_stored_ch  = 0;
    logic [31:0] lw [128];

    typedef struct {
        bit reload;
        int nch;
        int ppc;
        int gap;
        bit fixed;
        bit exp_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit want_gap(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic run(input vec_t v);
        bit          go_load;
        int          total;
        logic [31:0] d, last_in;
        Start = 1; Reload = v.reload; Num_Ch = 7'(v.nch); Pix_Per_Ch = 16'(v.ppc);
        tick();
        Start = 0;
        chk("err_pulse", Err, v.exp_err);
        chk("busy_after_start", Busy, !v.exp_err);
        if (v.exp_err) begin
            tick();
            chk("err_one_cycle", Err, 0);
            chk("busy_stays_low", Busy, 0);
            return;
        end
        go_load = v.reload || !m_coef_valid;
        if (go_load) begin
            for (int k = 0; k < 2 * v.nch; k++) begin
                if (want_gap(v.gap)) begin
                    Load_Valid = 0; Load_Data = $urandom;
                    tick();
                    chk("load_ready_gap", Load_Ready, 1);
                end
                chk("load_ready", Load_Ready, 1);
                chk("pix_ready_in_load", Pix_Ready, 0);
                Load_Valid = 1; Load_Data = lw[k];
                tick();
                Load_Valid = 0;
                if (k % 2 == 1) m_b[k / 2] = lw[k];
                else            m_a[k / 2] = lw[k];
            end
            m_coef_valid = 1;
            m_stored_ch  = v.nch;
        end
        total   = v.nch * v.ppc;
        last_in = Data_In;
        for (int i = 0; i < total; i++) begin
            if (want_gap(v.gap)) begin
                Pix_Valid = 0; Start = 1; Num_Ch = 0;
                tick();
                Start = 0;
                chk("valid_in_gap", Valid_In, 0);
                chk("data_in_held", Data_In, last_in);
                chk("start_ignored", Err, 0);
            end
            chk("pix_ready", Pix_Ready, 1);
            chk("load_ready_in_stream", Load_Ready, 0);
            d = $urandom;
            Pix_Valid = 1; Pix_Data = d;
            tick();
            Pix_Valid = 0;
            chk("valid_in", Valid_In, 1);
            chk("data_in", Data_In, d);
            chk("data_a", Data_A, m_a[i / v.ppc]);
            chk("data_b", Data_B, m_b[i / v.ppc]);
            chk("ch_idx", Ch_Idx, i / v.ppc);
            chk("done", Done, (i == total - 1));
            last_in = d;
        end
        chk("pix_ready_done", Pix_Ready, 0);
        chk("busy_done", Busy, 1);
        tick();
        chk("busy_idle", Busy, 0);
        chk("done_one_cycle", Done, 0);
        chk("valid_in_idle", Valid_In, 0);
        chk("data_in_hold_idle", Data_In, last_in);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_err"}, Err, 0);
        chk({tag, "_load_ready"}, Load_Ready, 0);
        chk({tag, "_pix_ready"}, Pix_Ready, 0);
        chk({tag, "_valid_in"}, Valid_In, 0);
        chk({tag, "_data_a"}, Data_A, 0);
        chk({tag, "_data_b"}, Data_B, 0);
        chk({tag, "_data_in"}, Data_In, 0);
        chk({tag, "_ch_idx"}, Ch_Idx, 0);
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{0, 2,  3, 0, 0, 1};
        vecs[1]  = '{1, 0,  3, 0, 0, 1};
        vecs[2]  = '{1, 65, 3, 0, 0, 1};
        vecs[3]  = '{1, 2,  0, 0, 0, 1};
        vecs[4]  = '{1, 2,  3, 0, 1, 0};
        vecs[5]  = '{0, 2,  3, 0, 0, 0};
        vecs[6]  = '{0, 3,  1, 0, 0, 1};
        vecs[7]  = '{1, 4,  5, 1, 0, 0};
        vecs[8]  = '{0, 4,  2, 2, 0, 0};
        vecs[9]  = '{1, 3,  4, 2, 0, 0};
        vecs[10] = '{1, 64, 1, 0, 0, 0};

        rst = 1; Start = 0; Reload = 0; Num_Ch = 0; Pix_Per_Ch = 0;
        Load_Valid = 0; Load_Data = 0; Pix_Valid = 0; Pix_Data = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 0;
        tick();

        for (int t = 0; t < 11; t++) begin
            for (int k = 0; k < 128; k++) lw[k] = $urandom;
            if (vecs[t].fixed) begin
                lw[0] = 32'h3F800000; lw[1] = 32'h00000000;
                lw[2] = 32'h40000000; lw[3] = 32'h3F800000;
            end
            run(vecs[t]);
            tick();
        end

        // reset in the middle of a coefficient load
        Start = 1; Reload = 1; Num_Ch = 4; Pix_Per_Ch = 2;
        tick();
        Start = 0;
        chk("midload_ready", Load_Ready, 1);
        for (int k = 0; k < 3; k++) begin
            Load_Valid = 1; Load_Data = $urandom;
            tick();
        end
        Load_Valid = 0;
        chk("midload_busy", Busy, 1);
        #2 rst = 1;
        #1;
        chk_all_zero("midload_rst");
        m_coef_valid = 0;
        m_stored_ch  = 0;
        @(negedge clk);
        rst = 0;
        tick();
        run('{0, 1, 1, 0, 0, 1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
